// File: rtl/cla_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor that walks one shared 4-bit
// carry-look-ahead adder across the operands, one nibble per clock.

module carry_look_ahead_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum_o  = p ^ c[3:0];
    cout_o = c[4];
  end
endmodule

module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16  // must be a multiple of 4 and at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic [1:0]       dbg_state_o
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: start_i is a request honoured only in IDLE or DONE; done_o is
  // a one-cycle pulse and sum/cout/overflow stay valid until the next accept.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        cla_sum;
  logic              cla_cout;
  logic              last_nib;

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (idx_q == IDXW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
    last_nib = (idx_q == IDXW'(NIB - 1));
  end

  carry_look_ahead_adder u_cla (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .sum_o  (cla_sum),
    .cout_o (cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            // Subtraction is a + ~b + 1, so the inversion happens at latch time.
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NIB; k++) begin
            if (idx_q == IDXW'(k)) sum_q[4*k +: 4] <= cla_sum;
          end
          carry_q <= cla_cout;
          if (last_nib) begin
            idx_q   <= '0;
            cout_q  <= cla_cout;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (cla_sum[3] != a_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Directed bench for cla_serial_adder_ctrl: expected results are queued at
// issue time and checked by an independent monitor when done pulses.

module tb_cla_serial_adder_ctrl;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         sub_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         overflow_o;
  logic [1:0]   dbg_state_o;

  int n_cmp;
  int n_err;
  int cyc;

  // Expected entry: {sum, cout, overflow}; done cycle held alongside.
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  cla_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .sub_i       (sub_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .overflow_o  (overflow_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("sum", 32'(sum_o), 32'(e[W+1:2]));
        chk("cout", 32'(cout_o), 32'(e[1]));
        chk("overflow", 32'(overflow_o), 32'(e[0]));
        chk("done_latency", 32'(cyc), 32'(ec));
        chk("busy_at_done", 32'(busy_o), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub; start_i = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    @(negedge clk);
    drive(a, b, cin, sub);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    exp_q.push_back({esum, ecout, eovf});
    exp_cyc_q.push_back(cyc + 4);
    chk({name, "_busy_after_start"}, 32'(busy_o), 32'd1);
    wait_done(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_sum"}, 32'(sum_o), 32'd0);
    chk({tag, "_cout"}, 32'(cout_o), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c1;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", 32'(dbg_state_o), 32'd0);

    run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start held high: op1 accepted, op2 operands present during RUN but only
    // accepted at the edge following the DONE cycle.
    @(negedge clk);
    drive(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    c1 = cyc;
    exp_q.push_back({16'h1000, 1'b0, 1'b0});
    exp_cyc_q.push_back(c1 + 4);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    exp_q.push_back({16'h0000, 1'b1, 1'b1});
    exp_cyc_q.push_back(c1 + 9);
    for (int i = 0; i < 20 && cyc < c1 + 5; i++) @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("b2b_busy_second", 32'(busy_o), 32'd1);
    wait_done("b2b_second");

    // Reset mid-run after two nibbles; aborted op must not produce done.
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_abort_idle", 32'(dbg_state_o), 32'd0);
    chk("post_abort_sum", 32'(sum_o), 32'd0);

    run_op("after_reset", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h4B4B, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
